// File: rtl/team_02_wb_responder.sv
// Wishbone classic slave backed by a word-addressed memory window.
// A hit is latched in IDLE, optionally delayed by WAIT_STATES cycles, then
// acknowledged for exactly one cycle. Writes honour byte-lane selects and
// acc_cnt_o counts every acknowledged transfer.
//
// Handshake: a request is offered while cyc_i & stb_i are high; it is taken
// at the first rising edge where the decoded address hits the window and the
// FSM is IDLE. The initiator must keep cyc_i & stb_i high until it samples
// ack_o=1; dropping either during WAIT abandons the transfer with no side
// effects. Address, data, select and direction are captured at acceptance,
// so later changes on those inputs have no effect on the transfer.
module team_02_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic [15:0] acc_cnt_o,
  output logic [1:0]  state_dbg
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  // Counter value loaded on acceptance; only meaningful when WAIT_STATES > 0.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [31:0]             dat_q;

  logic [31:0]             mem [DEPTH];

  logic                    hit;
  logic                    go_ack;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic                    cur_we;
  logic [3:0]              cur_sel;
  logic [31:0]             cur_dat;

  // Byte offset bits never select anything inside a 32-bit word.
  logic unused_adr;
  assign unused_adr = ^adr_i[1:0];

  assign hit       = cyc_i & stb_i &
                     (adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign state_dbg = state;

  // Decide whether this edge enters ACK, and which transfer attributes apply:
  // live inputs when going straight from IDLE, latched copies from WAIT.
  always_comb begin
    go_ack  = 1'b0;
    cur_idx = idx_q;
    cur_we  = we_q;
    cur_sel = sel_q;
    cur_dat = dat_q;
    case (state)
      S_IDLE: begin
        cur_idx = adr_i[DEPTH_LOG2+1:2];
        cur_we  = we_i;
        cur_sel = sel_i;
        cur_dat = dat_i;
        if (hit && (WAIT_STATES == 0)) go_ack = 1'b1;
      end
      S_WAIT: begin
        if (cyc_i && stb_i && (wait_cnt == 4'd0)) go_ack = 1'b1;
      end
      default: go_ack = 1'b0;
    endcase
  end

  // Storage update on the edge entering ACK; storage itself is never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && go_ack && cur_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  // Transfer FSM with registered ack/data/count outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      ack_o     <= 1'b0;
      dat_o     <= 32'd0;
      acc_cnt_o <= 16'd0;
    end else begin
      acc_cnt_o <= acc_cnt_o;
      if (go_ack) begin
        state     <= S_ACK;
        wait_cnt  <= 4'd0;
        ack_o     <= 1'b1;
        dat_o     <= cur_we ? 32'd0 : mem[cur_idx];
        acc_cnt_o <= acc_cnt_o + 16'd1;
      end else begin
        case (state)
          S_IDLE: begin
            ack_o <= 1'b0;
            dat_o <= 32'd0;
            if (hit) begin
              idx_q    <= adr_i[DEPTH_LOG2+1:2];
              we_q     <= we_i;
              sel_q    <= sel_i;
              dat_q    <= dat_i;
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
          S_WAIT: begin
            ack_o <= 1'b0;
            dat_o <= 32'd0;
            if (!(cyc_i && stb_i)) begin
              state    <= S_IDLE;
              wait_cnt <= 4'd0;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
          S_ACK: begin
            state <= S_IDLE;
            ack_o <= 1'b0;
            dat_o <= 32'd0;
          end
          default: begin
            state <= S_IDLE;
            ack_o <= 1'b0;
            dat_o <= 32'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_team_02_wb_responder.sv
// Bench for team_02_wb_responder: three instances (WAIT_STATES 2, 0, 3)
// share the bus signals; tgt selects which one sees cyc/stb.
module tb_team_02_wb_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  int          tgt;

  logic [2:0]  ack_w;
  logic [31:0] dout_w [3];
  logic [15:0] cnt_w [3];
  logic [1:0]  unused_st [3];

  int checks   = 0;
  int failures = 0;
  int ws_of [3] = '{2, 0, 3};

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [3][256];
  logic [3:0]  ref_bv  [3][256];
  logic [15:0] ref_cnt [3];

  team_02_wb_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .sel_i(sel), .we_i(we),
    .stb_i(stb && (tgt == 0)), .cyc_i(cyc && (tgt == 0)),
    .ack_o(ack_w[0]), .dat_o(dout_w[0]), .acc_cnt_o(cnt_w[0]), .state_dbg(unused_st[0]));

  team_02_wb_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .sel_i(sel), .we_i(we),
    .stb_i(stb && (tgt == 1)), .cyc_i(cyc && (tgt == 1)),
    .ack_o(ack_w[1]), .dat_o(dout_w[1]), .acc_cnt_o(cnt_w[1]), .state_dbg(unused_st[1]));

  team_02_wb_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .WAIT_STATES(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat), .sel_i(sel), .we_i(we),
    .stb_i(stb && (tgt == 2)), .cyc_i(cyc && (tgt == 2)),
    .ack_o(ack_w[2]), .dat_o(dout_w[2]), .acc_cnt_o(cnt_w[2]), .state_dbg(unused_st[2]));

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int d, input logic [7:0] idx, input logic [31:0] wd,
                             input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
        ref_bv[d][idx][b] = 1'b1;
      end
    end
  endtask

  // ---------------- driver: one complete transfer ----------------
  // Called #1 after a rising edge. Scrambles the bus after acceptance to
  // confirm captured attributes are used.
  task automatic xfer(input int d, input logic w, input logic [7:0] idx, input logic [1:0] lo,
                      input logic [31:0] wd, input logic [3:0] s, output logic [31:0] rd);
    logic        got;
    int          lat;
    logic [31:0] idle_or;
    got = 1'b0; lat = 0; rd = 32'd0; idle_or = 32'd0;
    tgt = d;
    adr = BASE | {22'd0, idx, lo};
    dat = wd; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (ack_w[d]) begin
        got = 1'b1; lat = i; rd = dout_w[d];
      end else begin
        idle_or |= dout_w[d];
        if (i == 1) begin
          adr = $urandom; dat = $urandom; sel = 4'($urandom_range(0, 15)); we = ~w;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    idle_or |= dout_w[d];
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(lat), 32'(ws_of[d] + 1));
    chk("ack_one_cycle", 32'(ack_w[d]), 32'd0);
    chk("dat_zero_without_ack", idle_or, 32'd0);
    if (got) begin
      ref_cnt[d] = ref_cnt[d] + 16'd1;
      if (w) model_write(d, idx, wd, s);
    end
    chk("acc_cnt", 32'(cnt_w[d]), 32'(ref_cnt[d]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        seen;
    logic [31:0] dor;
    logic [7:0]  r_idx;
    logic [1:0]  r_lo;
    logic        r_we;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [31:0] mask;

    for (int d = 0; d < 3; d++) begin
      ref_cnt[d] = 16'd0;
      for (int j = 0; j < 256; j++) begin
        ref_bv[d][j]  = 4'd0;
        ref_mem[d][j] = 32'd0;
      end
    end

    // Reset state.
    rst = 1'b1; adr = 32'd0; dat = 32'd0; sel = 4'd0; we = 1'b0; cyc = 1'b0; stb = 1'b0; tgt = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ack", 32'(ack_w[d]), 32'd0);
      chk("reset_dat", dout_w[d], 32'd0);
      chk("reset_cnt", 32'(cnt_w[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-word write then read back at BASE+0x10, two wait states.
    xfer(0, 1'b1, 8'h04, 2'b00, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 1'b0, 8'h04, 2'b11, 32'h0, 4'hF, rd);
    chk("basic_read", rd, 32'hDEADBEEF);
    chk("basic_cnt", 32'(cnt_w[0]), 32'd2);

    // Byte-lane merge, then a sel=0 write that must leave the word alone.
    xfer(0, 1'b1, 8'h08, 2'b00, 32'h11223344, 4'hF, rd);
    xfer(0, 1'b1, 8'h08, 2'b01, 32'hAABBCCDD, 4'b0101, rd);
    xfer(0, 1'b0, 8'h08, 2'b00, 32'h0, 4'hF, rd);
    chk("lane_merge", rd, 32'h11BB33DD);
    xfer(0, 1'b1, 8'h08, 2'b00, 32'hFFFFFFFF, 4'h0, rd);
    xfer(0, 1'b0, 8'h08, 2'b10, 32'h0, 4'hF, rd);
    chk("sel_zero_no_change", rd, 32'h11BB33DD);

    // Abort: strobe dropped one cycle after acceptance.
    xfer(0, 1'b1, 8'h0C, 2'b00, 32'h00000000, 4'hF, rd);
    tgt = 0; adr = BASE | 32'h30; dat = 32'hCAFEF00D; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= ack_w[0];
    end
    cyc = 1'b0;
    chk("abort_no_ack", 32'(seen), 32'd0);
    chk("abort_cnt", 32'(cnt_w[0]), 32'(ref_cnt[0]));
    xfer(0, 1'b0, 8'h0C, 2'b00, 32'h0, 4'hF, rd);
    chk("abort_read", rd, 32'h00000000);

    // Out-of-window read held for 20 cycles.
    tgt = 0; adr = BASE + (32'd4 << 8); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0; dor = 32'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen |= ack_w[0];
      dor  |= dout_w[0];
    end
    cyc = 1'b0; stb = 1'b0;
    chk("oow_no_ack", 32'(seen), 32'd0);
    chk("oow_dat_zero", dor, 32'd0);
    chk("oow_cnt", 32'(cnt_w[0]), 32'(ref_cnt[0]));
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      r_idx = 8'($urandom_range(0, 15));
      r_lo  = 2'($urandom_range(0, 3));
      r_we  = ($urandom_range(0, 1) == 1) || (ref_bv[0][r_idx] == 4'd0);
      r_dat = $urandom;
      r_sel = 4'($urandom_range(0, 15));
      xfer(0, r_we, r_idx, r_lo, r_dat, r_sel, rd);
      if (!r_we) begin
        mask = {{8{ref_bv[0][r_idx][3]}}, {8{ref_bv[0][r_idx][2]}},
                {8{ref_bv[0][r_idx][1]}}, {8{ref_bv[0][r_idx][0]}}};
        chk("rand_read", rd & mask, ref_mem[0][r_idx] & mask);
      end
    end

    // Zero wait states: back-to-back reads with strobe held.
    xfer(1, 1'b1, 8'h03, 2'b00, 32'h5A5AA5A5, 4'hF, rd);
    tgt = 1; adr = BASE | (32'd3 << 2); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack_pattern", 32'(ack_w[1]), 32'(i % 2));
      if (ack_w[1]) chk("b2b_data", dout_w[1], 32'h5A5AA5A5);
    end
    cyc = 1'b0; stb = 1'b0;
    ref_cnt[1] = ref_cnt[1] + 16'd6;
    @(posedge clk); #1;
    chk("b2b_cnt", 32'(cnt_w[1]), 32'(ref_cnt[1]));

    // Counter wrap from 16'hFFFF.
    force dut1.acc_cnt_o = 16'hFFFF;
    @(posedge clk); #1;
    release dut1.acc_cnt_o;
    ref_cnt[1] = 16'hFFFF;
    @(posedge clk); #1;
    chk("preload_cnt", 32'(cnt_w[1]), 32'h0000FFFF);
    xfer(1, 1'b0, 8'h03, 2'b00, 32'h0, 4'hF, rd);
    chk("wrap_cnt", 32'(cnt_w[1]), 32'd0);

    // Reset in the middle of a three-wait-state write.
    xfer(2, 1'b1, 8'h05, 2'b00, 32'h12345678, 4'hF, rd);
    tgt = 2; adr = BASE | (32'd5 << 2); dat = 32'h0BADF00D; sel = 4'hF; we = 1'b1;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midwait_rst_ack", 32'(ack_w[2]), 32'd0);
    chk("midwait_rst_cnt", 32'(cnt_w[2]), 32'd0);
    chk("midwait_rst_dat", dout_w[2], 32'd0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    for (int d = 0; d < 3; d++) ref_cnt[d] = 16'd0;
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h05, 2'b00, 32'h0, 4'hF, rd);
    chk("midwait_write_discarded", rd, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/team_02_wb_responder.md
TEAM_02_WB_RESPONDER -- requirements
Module: team_02_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the word-aligned base address of the responder window.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, so the window is 2^DEPTH_LOG2 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 2, range 0-15, the number of wait cycles inserted before ack_o.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port adr_i, input, 32 bits: Wishbone byte address from the initiator.
REQ-007 SHALL have port dat_i, input, 32 bits: write data.
REQ-008 SHALL have port sel_i, input, 4 bits: byte-lane select; bit n covers dat bits 8n+7:8n.
REQ-009 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port stb_i, input, 1 bit: strobe.
REQ-011 SHALL have port cyc_i, input, 1 bit: bus cycle valid.
REQ-012 SHALL have port ack_o, output, 1 bit: single-cycle acknowledge.
REQ-013 SHALL have port dat_o, output, 32 bits: read data.
REQ-014 SHALL have port acc_cnt_o, output, 16 bits: count of acknowledged transfers.

Function
REQ-015 SHALL decode hit = cyc_i & stb_i & (adr_i[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]), ignore adr_i[1:0], and index words with adr_i[DEPTH_LOG2+1:2].
REQ-016 SHALL implement FSM states IDLE, WAIT and ACK; IDLE is the reset state.
REQ-017 IDLE SHALL latch the word index, we_i, sel_i and dat_i when hit is sampled at edge k, then go to ACK if WAIT_STATES=0, else to WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-018 WAIT SHALL decrement the counter each edge and go to ACK at the edge where the counter equals 0, so ack_o rises right after edge k+WAIT_STATES and the initiator samples it at edge k+WAIT_STATES+1.
REQ-019 A write SHALL update only the byte lanes whose sel_i bit is set, at the edge entering ACK, using the values latched in IDLE; sel_i=0 SHALL still be acknowledged with no memory change.
REQ-020 A read SHALL drive dat_o with the addressed word while ack_o=1; dat_o SHALL be 0 whenever ack_o=0.
REQ-021 ACK SHALL last exactly one cycle and always return to IDLE, giving back-to-back throughput of one transfer per WAIT_STATES+2 cycles.
REQ-022 A drop of cyc_i or stb_i during WAIT SHALL abort the transfer: return to IDLE at that edge, no write, no ack, no count.
REQ-023 adr_i, dat_i, sel_i and we_i changes after acceptance SHALL be ignored.
REQ-024 A non-hit request SHALL never be acknowledged; the FSM stays in IDLE.
REQ-025 acc_cnt_o SHALL increment by 1 on each ACK cycle and wrap from 16'hFFFF to 0.

Reset
REQ-026 rst_i=1 at an edge SHALL force IDLE, ack_o=0, dat_o=0, acc_cnt_o=0 and wait counter=0; it takes priority over any transfer in progress, and a write not yet in ACK SHALL be discarded.
REQ-027 Memory contents SHALL NOT be reset and are undefined until written.

Verification
REQ-028 WAIT_STATES=2: write 32'hDEADBEEF, sel=4'hF to BASE+0x10 accepted at edge k -> ack_o high for one cycle after edge k+2; read BASE+0x10 -> dat_o=32'hDEADBEEF with ack; acc_cnt_o=2.
REQ-029 Byte lanes: write 32'h11223344 sel=4'hF, then 32'hAABBCCDD sel=4'b0101 to the same word -> read returns 32'h11BB33DD.
REQ-030 Abort: drop stb_i one cycle after acceptance of a write of 32'hCAFEF00D over existing 32'h0 -> no ack; subsequent read returns 32'h0; acc_cnt_o unchanged.
REQ-031 Out-of-window: read at BASE+(4<<DEPTH_LOG2) held 20 cycles -> ack_o stays 0, dat_o stays 0.
REQ-032 WAIT_STATES=0: back-to-back reads with stb_i held -> ack pulses every 2 cycles; rst_i asserted mid-WAIT (WAIT_STATES=3) -> ack_o=0 and acc_cnt_o=0 next cycle; a preload of acc_cnt_o to 16'hFFFF followed by one transfer -> acc_cnt_o=0.
